// File: rtl/stream_merge_arbiter.sv
// Round-robin merger of N first-word-fall-through FIFO streams into one registered
// valid/ready stream, with enable mask, burst limit, HOLD packet locking and ID stamping.
module stream_merge_arbiter #(
   parameter int unsigned CHANNELS  = 4,
   parameter int unsigned DWIDTH    = 32,
   parameter int unsigned ID_INSERT = 0,
   parameter int unsigned ID_BITS   = 4,
   parameter int unsigned MAX_BURST = 16
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [CHANNELS-1:0]          CH_ENABLE,
   input  logic [CHANNELS-1:0]          FIFO_EMPTY,
   input  logic [CHANNELS*DWIDTH-1:0]   FIFO_DATA,
   input  logic [CHANNELS-1:0]          HOLD_REQ,
   output logic [CHANNELS-1:0]          FIFO_READ,
   input  logic                         OUT_READY,
   output logic                         OUT_VALID,
   output logic [DWIDTH-1:0]            OUT_DATA,
   output logic [ID_BITS-1:0]           OUT_CHANNEL,
   output logic                         GRANT_ACTIVE
);

   localparam int unsigned GW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int unsigned BCW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [GW-1:0]       grant_q, grant_d;
   logic [GW-1:0]       ptr_q, ptr_d;
   logic [BCW-1:0]      burst_q, burst_d;
   logic                out_valid_q, out_valid_d;
   logic [DWIDTH-1:0]   out_data_q, out_data_d;
   logic [ID_BITS-1:0]  out_ch_q, out_ch_d;

   logic [CHANNELS-1:0] req;
   logic [DWIDTH-1:0]   ch_data [CHANNELS];
   logic [DWIDTH-1:0]   grant_word;
   logic [GW-1:0]       cand;
   logic [GW-1:0]       pick;
   logic                pick_found;
   logic                slot_free;
   logic                limit_hit;
   logic                xfer;
   logic                release_g;

   assign req       = CH_ENABLE & ~FIFO_EMPTY;
   assign slot_free = ~out_valid_q | OUT_READY;

   always_comb begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         ch_data[i] = FIFO_DATA[i*DWIDTH +: DWIDTH];
      end
   end

   // Word of the granted channel, optionally stamped with its index in the top bits
   always_comb begin
      grant_word = ch_data[grant_q];
      if (ID_INSERT != 0) begin
         grant_word[DWIDTH-1 -: ID_BITS] = ID_BITS'(grant_q);
      end
   end

   // Round-robin scan starting just after the last granted channel
   always_comb begin
      cand       = '0;
      pick       = '0;
      pick_found = 1'b0;
      for (int unsigned k = 1; k <= CHANNELS; k++) begin
         cand = GW'((32'(ptr_q) + k) % CHANNELS);
         if (!pick_found && req[cand]) begin
            pick_found = 1'b1;
            pick       = cand;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      ptr_d       = ptr_q;
      burst_d     = burst_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      FIFO_READ   = '0;
      limit_hit   = 1'b0;
      xfer        = 1'b0;
      release_g   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (OUT_READY) begin
               out_valid_d = 1'b0;
            end
            if (pick_found) begin
               grant_d = pick;
               burst_d = '0;
               state_d = S_GRANT;
            end
         end

         S_GRANT: begin
            limit_hit = (MAX_BURST != 0) && (burst_q == BCW'(MAX_BURST)) && !HOLD_REQ[grant_q];
            xfer      = req[grant_q] && slot_free && !limit_hit;
            release_g = !CH_ENABLE[grant_q] || (FIFO_EMPTY[grant_q] && !HOLD_REQ[grant_q]) ||
                        limit_hit;

            if (xfer) begin
               FIFO_READ[grant_q] = 1'b1;
               out_valid_d        = 1'b1;
               out_data_d         = grant_word;
               out_ch_d           = ID_BITS'(grant_q);
               if (burst_q != BCW'(MAX_BURST)) begin
                  burst_d = burst_q + BCW'(1);
               end
            end else if (OUT_READY) begin
               out_valid_d = 1'b0;
            end

            // A word popped this cycle is released from the updated flags next cycle
            if (release_g) begin
               state_d = S_IDLE;
               ptr_d   = grant_q;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= S_IDLE;
         grant_q     <= '0;
         ptr_q       <= GW'(CHANNELS - 1);
         burst_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         ptr_q       <= ptr_d;
         burst_q     <= burst_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
      end
   end

   assign OUT_VALID    = out_valid_q;
   assign OUT_DATA     = out_data_q;
   assign OUT_CHANNEL  = out_ch_q;
   assign GRANT_ACTIVE = (state_q == S_GRANT);

endmodule

// File: tb/tb_stream_merge_arbiter.sv
// Scoreboard bench for stream_merge_arbiter: queue-modelled FIFOs, transaction-level
// round-robin/burst predictor, and a monitor checking order, stability and pop legality.
module tb_stream_merge_arbiter;

   localparam int unsigned CH  = 4;
   localparam int unsigned DW  = 32;
   localparam int unsigned IDB = 4;
   localparam int unsigned MB  = 16;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic [CH-1:0]     CH_ENABLE = '0;
   logic [CH-1:0]     FIFO_EMPTY = '1;
   logic [CH*DW-1:0]  FIFO_DATA = '0;
   logic [CH-1:0]     HOLD_REQ = '0;
   logic [CH-1:0]     FIFO_READ;
   logic              OUT_READY = 1'b1;
   logic              OUT_VALID;
   logic [DW-1:0]     OUT_DATA;
   logic [IDB-1:0]    OUT_CHANNEL;
   logic              GRANT_ACTIVE;

   stream_merge_arbiter #(
      .CHANNELS(CH), .DWIDTH(DW), .ID_INSERT(1), .ID_BITS(IDB), .MAX_BURST(MB)
   ) dut (
      .CLK(CLK), .RST(RST), .CH_ENABLE(CH_ENABLE), .FIFO_EMPTY(FIFO_EMPTY),
      .FIFO_DATA(FIFO_DATA), .HOLD_REQ(HOLD_REQ), .FIFO_READ(FIFO_READ),
      .OUT_READY(OUT_READY), .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA),
      .OUT_CHANNEL(OUT_CHANNEL), .GRANT_ACTIVE(GRANT_ACTIVE)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [DW-1:0]  data;
      logic [IDB-1:0] ch;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] fq[CH][$];
   int            pops[CH];
   int            vectors = 0;
   int            miscompares = 0;
   int            m_ptr = CH - 1;
   int            ready_mode = 0;
   logic [CH-1:0] rd_s = '0;
   logic          stall_prev = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic [IDB-1:0] prev_ch = '0;

   initial for (int i = 0; i < CH; i++) pops[i] = 0;

   function automatic logic [DW-1:0] tag(input logic [DW-1:0] d, input int ch);
      logic [DW-1:0] r;
      r = d;
      r[DW-1 -: IDB] = IDB'(ch);
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // FIFO model: pop on strobes sampled at the previous falling edge, then present new head
   always @(posedge CLK) begin
      for (int i = 0; i < CH; i++) begin
         if (rd_s[i] && !RST) begin
            if (fq[i].size() > 0) void'(fq[i].pop_front());
            pops[i]++;
         end
      end
      #1;
      for (int i = 0; i < CH; i++) begin
         FIFO_EMPTY[i] = (fq[i].size() == 0);
         FIFO_DATA[i*DW +: DW] = (fq[i].size() > 0) ? fq[i][0] : '0;
      end
   end

   // Downstream ready pattern
   always @(posedge CLK) begin
      #1;
      case (ready_mode)
         0: OUT_READY = 1'b1;
         1: OUT_READY = 1'($urandom_range(0, 1));
         2: OUT_READY = ~OUT_READY;
         default: OUT_READY = 1'b0;
      endcase
   end

   // Monitor
   always @(negedge CLK) begin
      exp_t e;
      rd_s = FIFO_READ;
      if (RST) begin
         stall_prev = 1'b0;
      end else begin
         if (FIFO_READ != '0) begin
            check("read_onehot", 64'($onehot(FIFO_READ)), 64'd1);
            check("read_enabled", 64'(FIFO_READ & ~CH_ENABLE), 64'd0);
            check("read_nonempty", 64'(FIFO_READ & FIFO_EMPTY), 64'd0);
         end
         if (stall_prev) begin
            check("stall_valid", 64'(OUT_VALID), 64'd1);
            check("stall_data", 64'(OUT_DATA), 64'(prev_data));
            check("stall_ch", 64'(OUT_CHANNEL), 64'(prev_ch));
         end
         if (OUT_VALID && OUT_READY) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_word: got 0x%0h ch %0d, expected none at %0t",
                        OUT_DATA, OUT_CHANNEL, $time);
            end else begin
               e = exp_q.pop_front();
               check("out_data", 64'(OUT_DATA), 64'(e.data));
               check("out_ch", 64'(OUT_CHANNEL), 64'(e.ch));
            end
         end
         stall_prev = OUT_VALID && !OUT_READY;
         prev_data  = OUT_DATA;
         prev_ch    = OUT_CHANNEL;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #2;
   endtask

   task automatic load(input int ch, input int n);
      for (int j = 0; j < n; j++) fq[ch].push_back($urandom);
   endtask

   task automatic expect_word(input int ch, input logic [DW-1:0] d);
      exp_t e;
      e.data = tag(d, ch);
      e.ch   = IDB'(ch);
      exp_q.push_back(e);
   endtask

   // Transaction-level predictor for preloaded, static FIFO contents
   task automatic plan(input logic [CH-1:0] en);
      int cnt[CH];
      int idx[CH];
      int g, n;
      for (int i = 0; i < CH; i++) begin
         cnt[i] = en[i] ? fq[i].size() : 0;
         idx[i] = 0;
      end
      forever begin
         g = -1;
         for (int k = 1; k <= CH; k++) begin
            if (g < 0 && cnt[(m_ptr + k) % CH] > 0) g = (m_ptr + k) % CH;
         end
         if (g < 0) break;
         n = (cnt[g] > MB) ? MB : cnt[g];
         for (int j = 0; j < n; j++) expect_word(g, fq[g][idx[g] + j]);
         idx[g] += n;
         cnt[g] -= n;
         m_ptr = g;
      end
   endtask

   task automatic drain(input string name, input int budget);
      int c;
      c = 0;
      while ((exp_q.size() != 0 || OUT_VALID) && c < budget) begin
         tick(1);
         c++;
      end
      check({"drain_", name}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      tick(3);
   endtask

   function automatic int total_pops();
      int s;
      s = 0;
      for (int i = 0; i < CH; i++) s += pops[i];
      return s;
   endfunction

   initial begin
      int p0, c;
      int sz0[CH];
      logic [DW-1:0] w[8];
      logic [CH-1:0] en;

      tick(3);
      check("rst_valid", 64'(OUT_VALID), 64'd0);
      check("rst_grant", 64'(GRANT_ACTIVE), 64'd0);
      check("rst_read", 64'(FIFO_READ), 64'd0);
      check("rst_data", 64'(OUT_DATA), 64'd0);
      check("rst_ch", 64'(OUT_CHANNEL), 64'd0);
      RST = 1'b0;
      CH_ENABLE = '1;
      tick(2);

      // Three words per channel, free-flowing output
      p0 = total_pops();
      for (int i = 0; i < CH; i++) load(i, 3);
      plan(CH_ENABLE);
      drain("t1", 300);
      check("t1_pops", 64'(total_pops() - p0), 64'd12);

      // Burst limit: ch1 40 words vs ch2 5 words
      load(1, 40);
      load(2, 5);
      plan(CH_ENABLE);
      drain("t2", 600);

      // ID stamping under 1010 back-pressure
      ready_mode = 2;
      fq[2].push_back(32'h0ABCDEF1);
      begin
         exp_t e;
         e.data = 32'h2ABCDEF1;
         e.ch   = 4'd2;
         exp_q.push_back(e);
      end
      w[0] = $urandom;
      w[1] = $urandom;
      fq[2].push_back(w[0]);
      fq[2].push_back(w[1]);
      expect_word(2, w[0]);
      expect_word(2, w[1]);
      m_ptr = 2;
      drain("id", 200);
      ready_mode = 0;

      // Reset while a word sits stalled in the output register
      ready_mode = 3;
      tick(2);
      load(1, 5);
      c = 0;
      while (!OUT_VALID && c < 30) begin
         tick(1);
         c++;
      end
      check("rst_pre_valid", 64'(OUT_VALID), 64'd1);
      RST = 1'b1;
      #1;
      check("rst_async_valid", 64'(OUT_VALID), 64'd0);
      check("rst_async_read", 64'(FIFO_READ), 64'd0);
      check("rst_async_gact", 64'(GRANT_ACTIVE), 64'd0);
      for (int i = 0; i < CH; i++) fq[i].delete();
      exp_q.delete();
      m_ptr = CH - 1;
      ready_mode = 0;
      tick(2);
      RST = 1'b0;
      tick(1);
      load(0, 2);
      load(3, 2);
      plan(CH_ENABLE);
      drain("post_rst", 200);

      // HOLD keeps ch0 granted across an empty gap
      HOLD_REQ = 4'b0001;
      for (int j = 0; j < 7; j++) w[j] = $urandom;
      fq[0].push_back(w[0]);
      fq[0].push_back(w[1]);
      fq[3].push_back(w[4]);
      fq[3].push_back(w[5]);
      fq[3].push_back(w[6]);
      expect_word(0, w[0]);
      expect_word(0, w[1]);
      expect_word(0, w[2]);
      expect_word(0, w[3]);
      expect_word(3, w[4]);
      expect_word(3, w[5]);
      expect_word(3, w[6]);
      tick(10);
      check("hold_ch3_waiting", 64'(fq[3].size()), 64'd3);
      check("hold_grant", 64'(GRANT_ACTIVE), 64'd1);
      fq[0].push_back(w[2]);
      fq[0].push_back(w[3]);
      c = 0;
      while (fq[0].size() != 0 && c < 50) begin
         tick(1);
         c++;
      end
      tick(3);
      check("hold_ch3_still", 64'(fq[3].size()), 64'd3);
      HOLD_REQ = '0;
      drain("hold", 200);
      m_ptr = 3;

      // Disable ch1 mid-burst after two pops, re-enable later
      for (int j = 0; j < 8; j++) begin
         w[j] = $urandom;
         fq[1].push_back(w[j]);
      end
      expect_word(1, w[0]);
      expect_word(1, w[1]);
      p0 = pops[1];
      c = 0;
      while ((pops[1] - p0) < 2 && c < 50) begin
         tick(1);
         c++;
      end
      CH_ENABLE[1] = 1'b0;
      check("en_two_pops", 64'(pops[1] - p0), 64'd2);
      for (int j = 0; j < 4; j++) begin
         logic [DW-1:0] d;
         d = $urandom;
         fq[2].push_back(d);
         expect_word(2, d);
      end
      drain("en_ch2", 200);
      check("en_ch1_left", 64'(fq[1].size()), 64'd6);
      CH_ENABLE[1] = 1'b1;
      for (int j = 2; j < 8; j++) expect_word(1, w[j]);
      drain("en_resume", 200);
      m_ptr = 1;

      // Randomized rounds: random lengths, enable masks and back-pressure
      for (int r = 0; r < 9; r++) begin
         ready_mode = r % 3;
         en = 4'($urandom);
         CH_ENABLE = en;
         for (int i = 0; i < CH; i++) begin
            load(i, $urandom_range(0, 40));
            sz0[i] = fq[i].size();
         end
         plan(en);
         drain("rnd", 4000);
         for (int i = 0; i < CH; i++) begin
            if (!en[i]) check("rnd_disabled_untouched", 64'(fq[i].size()), 64'(sz0[i]));
            fq[i].delete();
         end
         tick(2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
